// File: rtl/ad9516_pkg.sv
// Shared state encoding, default timing parameters and counter sizing helper
// for the AD9516 configuration sequencer.
package ad9516_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWR_WAIT  = 3'd1,
    ST_CFG1      = 3'd2,
    ST_CFG2      = 3'd3,
    ST_LOCK_WAIT = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  localparam int DEF_POWERUP_DLY  = 1000;
  localparam int DEF_BUSY_TIMEOUT = 65535;
  localparam int DEF_LOCK_STABLE  = 256;
  localparam int DEF_LOCK_TIMEOUT = 1000000;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_AUTO_RELOCK  = 1;

  // Cycles after a start pulse during which a writer's busy is not trusted.
  localparam int BUSY_IGNORE = 2;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ad9516_cfg_sequencer_if.sv
// Start/busy handshake between the sequencer and the two AD9516 SPI writers.
// start is a one-cycle request; the writer raises busy within two cycles and
// keeps it high until its write completes; busy low afterwards means done.
interface ad9516_cfg_sequencer_if;
  logic ad9516_1_start_o;
  logic ad9516_2_start_o;
  logic ad9516_1_busy_i;
  logic ad9516_2_busy_i;

  modport master (
    output ad9516_1_start_o,
    output ad9516_2_start_o,
    input  ad9516_1_busy_i,
    input  ad9516_2_busy_i
  );

  modport slave (
    input  ad9516_1_start_o,
    input  ad9516_2_start_o,
    output ad9516_1_busy_i,
    output ad9516_2_busy_i
  );
endinterface

// File: rtl/ad9516_status_sync.sv
// Two-flop synchroniser for an asynchronous AD9516 PLL STATUS pin.
module ad9516_status_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= async_i;
      r_sync <= r_meta;
    end
  end

  assign sync_o = r_sync;
endmodule

// File: rtl/ad9516_cfg_sequencer.sv
// Power-up wait, ordered SPI configuration of two AD9516 devices, PLL lock
// qualification with retries, and lock-loss supervision.
module ad9516_cfg_sequencer
  import ad9516_pkg::*;
#(
  parameter int POWERUP_DLY  = DEF_POWERUP_DLY,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int AUTO_RELOCK  = DEF_AUTO_RELOCK
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_n_i,
  input  logic                          cfg_req_i,
  input  logic                          ad9516_1_status_i,
  input  logic                          ad9516_2_status_i,
  ad9516_cfg_sequencer_if.master        spi,
  output logic                          cfg_done_o,
  output logic                          cfg_err_o,
  output logic                          lock_lost_o,
  output logic [1:0]                    retry_cnt_o,
  output logic [2:0]                    state_o
);

  localparam int PWR_W  = cnt_w(POWERUP_DLY);
  localparam int BUSY_W = cnt_w((BUSY_TIMEOUT > BUSY_IGNORE + 1) ? BUSY_TIMEOUT : BUSY_IGNORE + 1);
  localparam int STAB_W = cnt_w(LOCK_STABLE);
  localparam int LOCK_W = cnt_w(LOCK_TIMEOUT);

  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(POWERUP_DLY - 1);
  localparam logic [BUSY_W-1:0] BUSY_LIM  = BUSY_W'(BUSY_TIMEOUT);
  localparam logic [BUSY_W-1:0] BUSY_IGN  = BUSY_W'(BUSY_IGNORE);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

  state_e              r_state;
  logic [PWR_W-1:0]    r_pwr_cnt;
  logic [BUSY_W-1:0]   r_busy_cnt;
  logic [STAB_W-1:0]   r_stable_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic                r_boot;
  logic                r_start1;
  logic                r_start2;
  logic                r_done;
  logic                r_err;
  logic                r_lost;
  logic [1:0]          r_retry;

  logic w_stat1;
  logic w_stat2;
  logic w_locked;
  logic w_in_cfg;
  logic w_busy_cur;
  logic w_cfg_go;
  logic w_cfg_fail;
  logic w_lock_ok;
  logic w_lock_fail;
  logic w_fail;

  ad9516_status_sync u_sync1 (
    .clk_i   (sys_clk_i),
    .rst_n_i (rst_n_i),
    .async_i (ad9516_1_status_i),
    .sync_o  (w_stat1)
  );

  ad9516_status_sync u_sync2 (
    .clk_i   (sys_clk_i),
    .rst_n_i (rst_n_i),
    .async_i (ad9516_2_status_i),
    .sync_o  (w_stat2)
  );

  assign w_locked    = w_stat1 & w_stat2;
  assign w_in_cfg    = (r_state == ST_CFG1) || (r_state == ST_CFG2);
  assign w_busy_cur  = (r_state == ST_CFG1) ? spi.ad9516_1_busy_i : spi.ad9516_2_busy_i;
  // r_busy_cnt is the number of cycles since the start pulse in this CFG state.
  assign w_cfg_go    = (r_busy_cnt > BUSY_IGN) && !w_busy_cur;
  assign w_cfg_fail  = !w_cfg_go && (r_busy_cnt >= BUSY_LIM);
  assign w_lock_ok   = w_locked && (r_stable_cnt == STAB_LAST);
  assign w_lock_fail = !w_lock_ok && (r_lock_cnt == LOCK_LAST);
  assign w_fail      = (w_in_cfg && w_cfg_fail) || ((r_state == ST_LOCK_WAIT) && w_lock_fail);

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_boot       <= 1'b1;
      r_pwr_cnt    <= '0;
      r_busy_cnt   <= '0;
      r_stable_cnt <= '0;
      r_lock_cnt   <= '0;
      r_start1     <= 1'b0;
      r_start2     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_lost       <= 1'b0;
      r_retry      <= 2'd0;
    end else begin
      r_start1 <= 1'b0;
      r_start2 <= 1'b0;
      if (w_fail) begin
        if (r_retry < RETRY_MAX) begin
          r_retry   <= r_retry + 2'd1;
          r_state   <= ST_PWR_WAIT;
          r_pwr_cnt <= '0;
        end else begin
          r_state <= ST_ERR;
          r_err   <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_boot || cfg_req_i) begin
              r_boot    <= 1'b0;
              r_state   <= ST_PWR_WAIT;
              r_pwr_cnt <= '0;
            end
          end
          ST_PWR_WAIT: begin
            if (r_pwr_cnt == PWR_LAST) begin
              r_state    <= ST_CFG1;
              r_start1   <= 1'b1;
              r_busy_cnt <= '0;
            end else begin
              r_pwr_cnt <= r_pwr_cnt + PWR_W'(1);
            end
          end
          ST_CFG1, ST_CFG2: begin
            if (w_cfg_go) begin
              r_busy_cnt <= '0;
              if (r_state == ST_CFG1) begin
                r_state  <= ST_CFG2;
                r_start2 <= 1'b1;
              end else begin
                r_state      <= ST_LOCK_WAIT;
                r_stable_cnt <= '0;
                r_lock_cnt   <= '0;
              end
            end else begin
              r_busy_cnt <= r_busy_cnt + BUSY_W'(1);
            end
          end
          ST_LOCK_WAIT: begin
            if (w_lock_ok) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_lock_cnt   <= r_lock_cnt + LOCK_W'(1);
              r_stable_cnt <= w_locked ? r_stable_cnt + STAB_W'(1) : '0;
            end
          end
          ST_DONE: begin
            // A request in the same cycle as a lock drop wins and leaves lock_lost clear.
            if (cfg_req_i) begin
              r_state   <= ST_PWR_WAIT;
              r_pwr_cnt <= '0;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              r_lost    <= 1'b0;
              r_retry   <= 2'd0;
            end else if (!w_locked && ((AUTO_RELOCK != 0) || r_done)) begin
              r_lost <= 1'b1;
              r_done <= 1'b0;
              if (AUTO_RELOCK != 0) begin
                r_retry   <= 2'd0;
                r_state   <= ST_PWR_WAIT;
                r_pwr_cnt <= '0;
              end
            end
          end
          ST_ERR: begin
            if (cfg_req_i) begin
              r_state   <= ST_PWR_WAIT;
              r_pwr_cnt <= '0;
              r_err     <= 1'b0;
              r_lost    <= 1'b0;
              r_retry   <= 2'd0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi.ad9516_1_start_o = r_start1;
  assign spi.ad9516_2_start_o = r_start2;
  assign cfg_done_o           = r_done;
  assign cfg_err_o            = r_err;
  assign lock_lost_o          = r_lost;
  assign retry_cnt_o          = r_retry;
  assign state_o              = r_state;

endmodule

// File: tb/tb_ad9516_cfg_sequencer.sv
// Bench for ad9516_cfg_sequencer: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed latencies.
module tb_ad9516_cfg_sequencer;

  localparam int P_DLY    = 10;
  localparam int B_TO     = 50;
  localparam int L_STAB   = 8;
  localparam int L_TO     = 100;
  localparam int M_RETRY  = 2;
  localparam int BUSY_LEN = 20;

  localparam int S_IDLE = 0, S_PWR = 1, S_CFG1 = 2, S_CFG2 = 3, S_LOCK = 4, S_DONE = 5, S_ERR = 6;
  localparam int C_LOST = 10, C_START1 = 11, C_DONE = 12, C_ERR = 13, C_RETRY1 = 14, C_START2 = 15;

  // ---------------- clock / reset / DUT ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic req    = 1'b0;
  logic stat1  = 1'b0;
  logic stat2  = 1'b0;
  logic       done_o, err_o, lost_o;
  logic [1:0] retry_o;
  logic [2:0] state_o;
  bit   stuck1 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int s1_q[$];

  ad9516_cfg_sequencer_if spi_if ();

  ad9516_cfg_sequencer #(
    .POWERUP_DLY  (P_DLY),
    .BUSY_TIMEOUT (B_TO),
    .LOCK_STABLE  (L_STAB),
    .LOCK_TIMEOUT (L_TO),
    .MAX_RETRY    (M_RETRY),
    .AUTO_RELOCK  (1)
  ) dut (
    .sys_clk_i         (clk),
    .rst_n_i           (rst_n),
    .cfg_req_i         (req),
    .ad9516_1_status_i (stat1),
    .ad9516_2_status_i (stat2),
    .spi               (spi_if),
    .cfg_done_o        (done_o),
    .cfg_err_o         (err_o),
    .lock_lost_o       (lost_o),
    .retry_cnt_o       (retry_o),
    .state_o           (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- SPI writer emulation ----------------
  initial begin : writers
    int rem1;
    int rem2;
    rem1 = 0;
    rem2 = 0;
    spi_if.ad9516_1_busy_i = 1'b0;
    spi_if.ad9516_2_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rem1 = 0;
        rem2 = 0;
      end else begin
        if (spi_if.ad9516_1_start_o) rem1 = BUSY_LEN; else if (rem1 > 0) rem1--;
        if (spi_if.ad9516_2_start_o) rem2 = BUSY_LEN; else if (rem2 > 0) rem2--;
      end
      spi_if.ad9516_1_busy_i = stuck1 || (rem1 > 0);
      spi_if.ad9516_2_busy_i = (rem2 > 0);
    end
  end

  // ---------------- reference model ----------------
  // Phases are tracked by entry timestamps rather than counters.
  bit m_valid = 1'b0;
  bit m_boot;
  int m_ph, m_t0, m_low;
  bit h1a, h1b, h2a, h2b;
  bit e_st1, e_st2, e_done, e_err, e_lost;
  int e_retry;

  always @(posedge clk) begin : model
    int  now;
    int  k;
    bit  s1, s2, b, fail;
    now = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_ph = S_IDLE; m_boot = 1'b1; m_t0 = now + 1; m_low = now;
      h1a = 1'b0; h1b = 1'b0; h2a = 1'b0; h2b = 1'b0;
      e_st1 = 1'b0; e_st2 = 1'b0; e_done = 1'b0; e_err = 1'b0; e_lost = 1'b0; e_retry = 0;
    end else begin
      s1 = h1b; s2 = h2b;
      h1b = h1a; h1a = stat1; h2b = h2a; h2a = stat2;
      b = (m_ph == S_CFG1) ? spi_if.ad9516_1_busy_i : spi_if.ad9516_2_busy_i;
      e_st1 = 1'b0; e_st2 = 1'b0; fail = 1'b0;
      case (m_ph)
        S_IDLE: if (m_boot || req) begin m_boot = 1'b0; m_ph = S_PWR; m_t0 = now + 1; end
        S_PWR: if (now - m_t0 + 1 == P_DLY) begin m_ph = S_CFG1; m_t0 = now + 1; e_st1 = 1'b1; end
        S_CFG1, S_CFG2: begin
          k = now - m_t0;
          if (k > 2 && !b) begin
            if (m_ph == S_CFG1) begin m_ph = S_CFG2; e_st2 = 1'b1; end
            else begin m_ph = S_LOCK; m_low = now; end
            m_t0 = now + 1;
          end else if (k >= B_TO) fail = 1'b1;
        end
        S_LOCK: begin
          if (!(s1 && s2)) m_low = now;
          if (now - m_low == L_STAB) begin m_ph = S_DONE; e_done = 1'b1; end
          else if (now - m_t0 + 1 == L_TO) fail = 1'b1;
        end
        S_DONE: begin
          if (req) begin
            e_lost = 1'b0; e_err = 1'b0; e_retry = 0; e_done = 1'b0; m_ph = S_PWR; m_t0 = now + 1;
          end else if (!(s1 && s2)) begin
            e_lost = 1'b1; e_done = 1'b0; e_retry = 0; m_ph = S_PWR; m_t0 = now + 1;
          end
        end
        S_ERR: if (req) begin e_err = 1'b0; e_lost = 1'b0; e_retry = 0; m_ph = S_PWR; m_t0 = now + 1; end
        default: m_ph = S_IDLE;
      endcase
      if (fail) begin
        if (e_retry < M_RETRY) begin e_retry++; m_ph = S_PWR; m_t0 = now + 1; end
        else begin m_ph = S_ERR; e_err = 1'b1; end
      end
    end
    m_valid = 1'b1;
  end

  function automatic logic [9:0] dut_vec();
    return {state_o, spi_if.ad9516_1_start_o, spi_if.ad9516_2_start_o, done_o, err_o, lost_o, retry_o};
  endfunction

  always @(negedge clk) begin : compare
    logic [9:0] exp_v;
    logic [9:0] act_v;
    if (m_valid) begin
      exp_v = {3'(m_ph), e_st1, e_st2, e_done, e_err, e_lost, 2'(e_retry)};
      act_v = dut_vec();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle cyc=%0d: dut=%b model=%b (state,st1,st2,done,err,lost,retry)", cyc, act_v, exp_v);
      end
    end
  end

  always @(negedge clk) if (spi_if.ad9516_1_start_o === 1'b1) s1_q.push_back(cyc);

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit cond(input int code);
    case (code)
      C_LOST:   return lost_o === 1'b1;
      C_START1: return spi_if.ad9516_1_start_o === 1'b1;
      C_START2: return spi_if.ad9516_2_start_o === 1'b1;
      C_DONE:   return done_o === 1'b1;
      C_ERR:    return err_o === 1'b1;
      C_RETRY1: return retry_o === 2'd1;
      default:  return state_o === 3'(code);
    endcase
  endfunction

  task automatic wait_until(input string name, input int code, input int budget, output int at);
    int k;
    k = 0;
    @(negedge clk);
    while (!cond(code) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!cond(code)) begin
      n_bad++;
      $display("FAIL %s: event not seen within %0d cycles", name, budget);
    end
    at = cyc;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int t_a, t_b, t_c, t_x;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 0);
    rst_n = 1'b1;

    // Nominal bring-up, status rises only once LOCK_WAIT is reached.
    wait_until("enter_pwr_wait", S_PWR, 5, t_a);
    wait_until("start1_nominal", C_START1, 20, t_b);
    check("start1_after_pwr", 32'(t_b - t_a), 10);
    wait_until("start2_nominal", C_START2, 40, t_c);
    check("start2_after_start1", 32'(t_c - t_b), 21);
    check("busy1_low_at_start2", 32'(spi_if.ad9516_1_busy_i), 0);
    wait_until("lock_wait_nominal", S_LOCK, 40, t_a);
    stat1 = 1'b1;
    stat2 = 1'b1;
    wait_until("done_nominal", C_DONE, 30, t_b);
    check("done_latency", 32'(t_b - t_a), 10);
    check("retry_nominal", 32'(retry_o), 0);

    // Lock loss in DONE with automatic relock.
    repeat (3) @(negedge clk);
    stat1 = 1'b0;
    t_x = cyc;
    wait_until("lock_lost", C_LOST, 10, t_a);
    check("lost_latency", 32'(t_a - t_x), 3);
    check("done_cleared_on_loss", 32'(done_o), 0);
    stat1 = 1'b1;
    wait_until("start1_relock", C_START1, 20, t_b);
    check("relock_start1_delay", 32'(t_b - t_a), 10);
    wait_until("done_relock", C_DONE, 100, t_c);
    check("lost_sticky", 32'(lost_o), 1);

    // Request and lock drop seen in the same DONE cycle: request wins.
    repeat (2) @(negedge clk);
    stat1 = 1'b0;
    stat2 = 1'b0;
    repeat (2) @(negedge clk);
    pulse_req();
    check("req_vs_loss_state", 32'(state_o), S_PWR);
    check("req_vs_loss_lost", 32'(lost_o), 0);

    // Glitch on status2 after 5 stable cycles restarts the stable count.
    wait_until("lock_wait_glitch", S_LOCK, 80, t_a);
    stat1 = 1'b1;
    stat2 = 1'b1;
    repeat (5) @(negedge clk);
    stat2 = 1'b0;
    @(negedge clk);
    stat2 = 1'b1;
    wait_until("done_glitch", C_DONE, 30, t_b);
    check("done_after_glitch", 32'(t_b - t_a), 16);

    // Device 1 busy stuck high: two retries then ERR.
    stuck1 = 1'b1;
    s1_q.delete();
    pulse_req();
    wait_until("err_stuck", C_ERR, 400, t_a);
    check("stuck_start1_pulses", 32'(s1_q.size()), 3);
    if (s1_q.size() >= 2) check("stuck_retry_spacing", 32'(s1_q[1] - s1_q[0]), 61);
    check("stuck_state", 32'(state_o), S_ERR);
    check("stuck_retry", 32'(retry_o), 2);

    // Request in ERR re-sequences; request in CFG2 is ignored; lock timeout retries.
    stuck1 = 1'b0;
    stat1 = 1'b0;
    stat2 = 1'b0;
    pulse_req();
    check("err_cleared", 32'(err_o), 0);
    check("err_req_state", 32'(state_o), S_PWR);
    wait_until("cfg2_reached", S_CFG2, 60, t_a);
    pulse_req();
    check("req_ignored_cfg2", 32'(state_o), S_CFG2);
    wait_until("lock_wait_timeout", S_LOCK, 40, t_a);
    wait_until("lock_timeout_retry", C_RETRY1, 150, t_b);
    check("lock_timeout_len", 32'(t_b - t_a), 100);
    check("lock_timeout_state", 32'(state_o), S_PWR);
    stat1 = 1'b1;
    stat2 = 1'b1;
    wait_until("done_after_timeout", C_DONE, 150, t_c);
    check("retry_after_timeout", 32'(retry_o), 1);

    // Reset while in CFG1 clears every output on the next cycle.
    pulse_req();
    wait_until("cfg1_before_reset", S_CFG1, 30, t_a);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_cfg1", 32'(dut_vec()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until("done_after_reset", C_DONE, 150, t_b);
    check("retry_after_reset", 32'(retry_o), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
